// File: rtl/fsm_slave_if.sv
// -----------------------------------------------------------------------------
// fsm_slave_if
//
// Local-side bundle of the I2C target controller: the bytes it returns on a
// read, the bytes it captured on a write, and its transfer status.
//
//   tx_data_1/2  first/second byte returned on a bus read
//   rx_data_1/2  first/second byte captured on a bus write
//   rx_valid     one-cycle pulse, two-byte write complete
//   tx_done      one-cycle pulse, second read byte shifted out
//   addr_match   own address ACKed, held until STOP/START/reset
//   busy         START seen, STOP not yet seen
//   state_slave  current FSM state (debug)
//
// Modports: slave (the controller), master (local logic / testbench).
// -----------------------------------------------------------------------------
interface fsm_slave_if #(
    parameter int DATA_LEN = 8
);
    logic [DATA_LEN-1:0] tx_data_1;
    logic [DATA_LEN-1:0] tx_data_2;
    logic [DATA_LEN-1:0] rx_data_1;
    logic [DATA_LEN-1:0] rx_data_2;
    logic                rx_valid;
    logic                tx_done;
    logic                addr_match;
    logic                busy;
    logic [3:0]          state_slave;

    modport slave (
        input  tx_data_1, tx_data_2,
        output rx_data_1, rx_data_2, rx_valid, tx_done, addr_match, busy, state_slave
    );

    modport master (
        output tx_data_1, tx_data_2,
        input  rx_data_1, rx_data_2, rx_valid, tx_done, addr_match, busy, state_slave
    );
endinterface

// File: rtl/fsm_slave.sv
// -----------------------------------------------------------------------------
// fsm_slave
//
// I2C target controller. Oversamples scl/sda on clk, detects START/STOP,
// matches a 7-bit address, ACKs, then receives two bytes (write) or sends
// two bytes (read). Never stretches scl; sda is only ever pulled low or
// released.
//
// Ports:
//   clk    system clock, at least 4x the scl rate
//   rst_n  asynchronous active-low reset
//   scl    bus clock (input only)
//   sda    bus data, open-drain
//   host   local side (fsm_slave_if.slave): tx bytes in, rx bytes/status out
//
// Build option:
//   SLAVE_GLITCH_FILTER_EN  adds a 3-sample majority filter after the
//                           synchronizers (+2 cycles pin-to-edge latency).
// -----------------------------------------------------------------------------
module fsm_slave #(
    parameter int                  ADDR_LEN   = 7,
    parameter int                  DATA_LEN   = 8,
    parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = 7'h2A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scl,
    inout  wire          sda,
    fsm_slave_if.slave   host
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] RX_DATA   = 3'd3;
    localparam logic [2:0] RX_ACK    = 3'd4;
    localparam logic [2:0] TX_DATA   = 3'd5;
    localparam logic [2:0] TX_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    localparam logic [3:0] BIT_LAST = 4'(DATA_LEN - 1);

    logic                scl_s1, scl_s2, sda_s1, sda_s2;
    logic                scl_c, sda_c, scl_d, sda_d;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]          state;
    logic [3:0]          bit_cnt;
    logic                byte_cnt;
    logic                in_ack;     // second half of an ACK slot: first scl fall seen
    logic                sda_oe;     // 1 = pull sda low
    logic [DATA_LEN-1:0] shift_reg, shift_in, tx_reg1, tx_reg2;
    logic                addr_ok, addr_hit_in;

    // Open-drain: low or released, never a driven 1. sda_oe is an async-reset
    // flop, so reset releases the line without waiting for a clock.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    // Synchronizer flops reset to 1 (idle bus level) so leaving reset on an
    // idle bus does not look like an sda fall, i.e. a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl;  scl_s2 <= scl_s1;
            sda_s1 <= sda;  sda_s2 <= sda_s1;
        end
    end

`ifdef SLAVE_GLITCH_FILTER_EN
    // A single-cycle glitch never occupies two of the three samples at once.
    logic [1:0] scl_h, sda_h;
    logic       scl_f, sda_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h <= 2'b11; sda_h <= 2'b11;
            scl_f <= 1'b1;  sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_s2};
            sda_h <= {sda_h[0], sda_s2};
            scl_f <= (scl_s2 & scl_h[0]) | (scl_s2 & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda_f <= (sda_s2 & sda_h[0]) | (sda_s2 & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end

    assign scl_c = scl_f;
    assign sda_c = sda_f;
`else
    assign scl_c = scl_s2;
    assign sda_c = sda_s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_c;
            sda_d <= sda_c;
        end
    end

    assign scl_rise  =  scl_c & ~scl_d;
    assign scl_fall  = ~scl_c &  scl_d;
    // START/STOP need scl high on both samples so an sda change that merely
    // coincides with an scl edge is not mistaken for a bus condition.
    assign start_det =  scl_c & scl_d &  sda_d & ~sda_c;
    assign stop_det  =  scl_c & scl_d & ~sda_d &  sda_c;

    assign shift_in    = {shift_reg[DATA_LEN-2:0], sda_c};
    assign addr_hit_in = (shift_in[DATA_LEN-1 -: ADDR_LEN] == SLAVE_ADDR);
    assign addr_ok     = (shift_reg[DATA_LEN-1 -: ADDR_LEN] == SLAVE_ADDR);

    assign host.state_slave = {1'b0, state};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            byte_cnt        <= 1'b0;
            in_ack          <= 1'b0;
            sda_oe          <= 1'b0;
            shift_reg       <= '0;
            tx_reg1         <= '0;
            tx_reg2         <= '0;
            host.rx_data_1  <= '0;
            host.rx_data_2  <= '0;
            host.rx_valid   <= 1'b0;
            host.tx_done    <= 1'b0;
            host.addr_match <= 1'b0;
            host.busy       <= 1'b0;
        end else begin
            host.rx_valid <= 1'b0;
            host.tx_done  <= 1'b0;

            if (start_det) begin
                // Also a repeated START: any partial byte is simply dropped.
                state           <= ADDR;
                bit_cnt         <= '0;
                byte_cnt        <= 1'b0;
                in_ack          <= 1'b0;
                sda_oe          <= 1'b0;
                host.busy       <= 1'b1;
                host.addr_match <= 1'b0;
            end else if (stop_det) begin
                state           <= IDLE;
                bit_cnt         <= '0;
                in_ack          <= 1'b0;
                sda_oe          <= 1'b0;
                host.busy       <= 1'b0;
                host.addr_match <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= shift_in;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= ADDR_ACK;
                                if (addr_hit_in && shift_in[0]) begin
                                    tx_reg1 <= host.tx_data_1;
                                    tx_reg2 <= host.tx_data_2;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (!addr_ok) begin
                            sda_oe <= 1'b0;
                            state  <= WAIT_STOP;
                        end else if (scl_fall) begin
                            if (!in_ack) begin
                                in_ack          <= 1'b1;
                                sda_oe          <= 1'b1;
                                host.addr_match <= 1'b1;
                            end else begin
                                // End of ACK slot: hand the line straight to
                                // the first data bit (read) or release (write).
                                in_ack   <= 1'b0;
                                byte_cnt <= 1'b0;
                                if (shift_reg[0]) begin
                                    state     <= TX_DATA;
                                    sda_oe    <= ~tx_reg1[DATA_LEN-1];
                                    shift_reg <= {tx_reg1[DATA_LEN-2:0], 1'b0};
                                end else begin
                                    state  <= RX_DATA;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end

                    RX_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= shift_in;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= RX_ACK;
                                if (!byte_cnt) begin
                                    host.rx_data_1 <= shift_in;
                                end else begin
                                    host.rx_data_2 <= shift_in;
                                    host.rx_valid  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!in_ack) begin
                                in_ack <= 1'b1;
                                sda_oe <= 1'b1;
                            end else begin
                                in_ack <= 1'b0;
                                sda_oe <= 1'b0;
                                if (!byte_cnt) begin
                                    byte_cnt <= 1'b1;
                                    state    <= RX_DATA;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end

                    TX_DATA: begin
                        // The MSB was put on the line on entry; each fall
                        // presents the next bit.
                        if (scl_rise) begin
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= TX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall) begin
                            sda_oe    <= ~shift_reg[DATA_LEN-1];
                            shift_reg <= {shift_reg[DATA_LEN-2:0], 1'b0};
                        end
                    end

                    TX_ACK: begin
                        if (scl_fall) begin
                            if (!in_ack) begin
                                in_ack <= 1'b1;
                                sda_oe <= 1'b0;
                            end else begin
                                // Only reached after the master ACKed byte 1.
                                in_ack    <= 1'b0;
                                state     <= TX_DATA;
                                sda_oe    <= ~tx_reg2[DATA_LEN-1];
                                shift_reg <= {tx_reg2[DATA_LEN-2:0], 1'b0};
                            end
                        end else if (scl_rise && in_ack) begin
                            if (byte_cnt) begin
                                host.tx_done <= 1'b1;
                                in_ack       <= 1'b0;
                                state        <= WAIT_STOP;
                            end else if (sda_c) begin
                                in_ack <= 1'b0;
                                state  <= WAIT_STOP;
                            end else begin
                                byte_cnt <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP: line released, only bus
                        // conditions move the FSM.
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
